// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encodings and default data width.
// The encodings match the ones used by the adder and the ALU top.
package shift_add_multiplier_pkg;

    localparam int DATA_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier driving an external ripple adder.
// Optional feature: define MULT_EARLY_EXIT_EN to finish zero-operand multiplies in one cycle.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   A_in,
    input  logic [WIDTH-1:0]   B_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] P,
    output logic [WIDTH-1:0]   add_A,
    output logic [WIDTH-1:0]   add_B,
    output logic               add_CarryIN,
    input  logic [WIDTH-1:0]   add_Y,
    input  logic               add_CarryOUT
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]   acc_hi_r;
    logic [WIDTH-1:0]   mq_r;
    logic [CW-1:0]      cnt_r;
    logic [2*WIDTH-1:0] p_r;

    logic               load_s;
    logic               iter_s;
    logic               zero_s;
    logic               last_s;
    logic               carry_s;
    logic [WIDTH-1:0]   sum_s;
    logic [2*WIDTH-1:0] shifted_s;

    // Adder operands come straight from registers so there is no input-to-output path.
    assign add_A       = acc_hi_r;
    assign add_B       = mq_r[0] ? mcand_r : {WIDTH{1'b0}};
    assign add_CarryIN = 1'b0;

    assign busy = (state_r == CALC);
    assign done = (state_r == DONE);
    assign P    = p_r;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode, datapath controls and the shifted partial product.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        iter_s      = 1'b0;
        zero_s      = 1'b0;
        last_s      = (cnt_r == LAST_CNT);
        if (mq_r[0]) begin
            {carry_s, sum_s} = {add_CarryOUT, add_Y};
        end else begin
            {carry_s, sum_s} = {1'b0, acc_hi_r};
        end
        // The bit leaving mq each iteration is the multiplier bit just consumed.
        shifted_s = {carry_s, sum_s, mq_r[WIDTH-1:1]};
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
`ifdef MULT_EARLY_EXIT_EN
                    if ((A_in == {WIDTH{1'b0}}) || (B_in == {WIDTH{1'b0}})) begin
                        zero_s      = 1'b1;
                        state_nxt_s = DONE;
                    end else begin
                        load_s      = 1'b1;
                        state_nxt_s = CALC;
                    end
`else
                    load_s      = 1'b1;
                    state_nxt_s = CALC;
`endif
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                iter_s = 1'b1;
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Operand capture, iteration shift/accumulate and product register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_r  <= {WIDTH{1'b0}};
            acc_hi_r <= {WIDTH{1'b0}};
            mq_r     <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            p_r      <= {(2*WIDTH){1'b0}};
        end else if (load_s) begin
            mcand_r  <= A_in;
            mq_r     <= B_in;
            acc_hi_r <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else if (iter_s) begin
            {acc_hi_r, mq_r} <= shifted_s;
            cnt_r            <= cnt_r + CW'(1);
            if (last_s) begin
                p_r <= shifted_s;
            end
        end else if (zero_s) begin
            p_r <= {(2*WIDTH){1'b0}};
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier (WIDTH=4) with a behavioural 4-bit adder beside it.
module tb_shift_add_multiplier;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] A_in = 4'd0;
    logic [3:0] B_in = 4'd0;
    logic       busy;
    logic       done;
    logic [7:0] P;
    logic [3:0] add_A;
    logic [3:0] add_B;
    logic       add_CarryIN;
    logic [3:0] add_Y;
    logic       add_CarryOUT;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int busy_cnt = 0;

    typedef struct {
        logic [7:0] p;
        int         cyc;
        int         busy;
    } exp_t;
    exp_t sb[$];

    shift_add_multiplier #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .A_in(A_in), .B_in(B_in),
        .busy(busy), .done(done), .P(P),
        .add_A(add_A), .add_B(add_B), .add_CarryIN(add_CarryIN),
        .add_Y(add_Y), .add_CarryOUT(add_CarryOUT)
    );

    // External 4-bit adder
    assign {add_CarryOUT, add_Y} = {1'b0, add_A} + {1'b0, add_B} + {4'd0, add_CarryIN};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int latency(input logic [3:0] a, input logic [3:0] b);
`ifdef MULT_EARLY_EXIT_EN
        if (a == 4'd0 || b == 4'd0) return 0;
`endif
        return 4;
    endfunction

    // Monitor: pops the scoreboard on every done pulse
    always @(negedge clk) begin
        if (reset) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("product", int'(P), int'(e.p));
                    check("done_cycle", cyc, e.cyc);
                    check("busy_cycles", busy_cnt, e.busy);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [7:0] p);
        int lat;
        exp_t e;
        @(posedge clk); #1;
        A_in = a; B_in = b; start = 1'b1;
        lat = latency(a, b);
        e.p = p; e.cyc = cyc + 1 + lat; e.busy = lat;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #1;
        check("reset_P", int'(P), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;

        issue(4'd3, 4'd5, 8'd15);
        drain();
        repeat (3) @(posedge clk); #1;
        check("P_hold", int'(P), 15);

        issue(4'd15, 4'd15, 8'd225); drain();
        issue(4'd15, 4'd1, 8'd15);   drain();
        issue(4'd0, 4'd9, 8'd0);     drain();
        issue(4'd11, 4'd13, 8'd143); drain();

        // start pulse while busy must be ignored
        issue(4'd6, 4'd7, 8'd42);
        @(posedge clk); #1;
        A_in = 4'd2; B_in = 4'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drain();

        // reset mid-operation aborts without a done pulse
        @(posedge clk); #1;
        A_in = 4'd9; B_in = 4'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_P", int'(P), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        issue(4'd4, 4'd4, 8'd16); drain();

        // start held high: new operands sampled in the DONE cycle
        begin
            exp_t e;
            @(posedge clk); #1;
            A_in = 4'd2; B_in = 4'd3; start = 1'b1;
            e.p = 8'd6; e.cyc = cyc + 1 + 4; e.busy = 4;
            sb.push_back(e);
            repeat (5) @(posedge clk); #1;
            A_in = 4'd5; B_in = 4'd5;
            e.p = 8'd25; e.cyc = cyc + 1 + 4; e.busy = 4;
            sb.push_back(e);
            @(posedge clk); #1;
            start = 1'b0;
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
